// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - issue, register-file, operand and result bundle for regfile_access_ctrl
interface regfile_access_ctrl_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] issue_src_a;
    logic [1:0] issue_src_b;
    logic [1:0] issue_dst;
    logic       issue_wr;
    logic [1:0] selector_a;
    logic [1:0] selector_b;
    logic [7:0] data_out_a;
    logic [7:0] data_out_b;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] op_dst;
    logic       op_wr;
    logic       res_valid;
    logic [1:0] res_dst;
    logic [7:0] res_data;
    logic       write_bit;
    logic [1:0] selector_e;
    logic [7:0] data_in;
    logic       err;

    modport master (
        input  issue_valid, issue_src_a, issue_src_b, issue_dst, issue_wr,
        output issue_ready,
        output selector_a, selector_b,
        input  data_out_a, data_out_b,
        output op_valid, op_a, op_b, op_dst, op_wr,
        input  op_ready,
        input  res_valid, res_dst, res_data,
        output write_bit, selector_e, data_in, err
    );

    modport slave (
        output issue_valid, issue_src_a, issue_src_b, issue_dst, issue_wr,
        input  issue_ready,
        input  selector_a, selector_b,
        output data_out_a, data_out_b,
        input  op_valid, op_a, op_b, op_dst, op_wr,
        output op_ready,
        output res_valid, res_dst, res_data,
        input  write_bit, selector_e, data_in, err
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - register-file access controller with pending-write scoreboard
// Optional result forwarding into the operand slot is enabled by defining REGFILE_BYPASS_EN.
module regfile_access_ctrl #(
    parameter int MAX_PENDING = 4
) (
    input  logic                  CLK,
    input  logic                  areset,
    regfile_access_ctrl_if.master bus
);

    logic [3:0] pending_q, pending_d;
    logic [3:0] set_mask, clr_mask;
    logic       op_valid_q, op_valid_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic [1:0] op_dst_q, op_dst_d;
    logic       op_wr_q, op_wr_d;
    logic       err_q, err_d;

    logic [2:0] pend_cnt;
    logic       res_hit;
    logic       fwd_a, fwd_b;
    logic       raw, waw, full;
    logic       issue_ready;
    logic       accept;
    logic [7:0] opnd_a, opnd_b;

    assign bus.selector_a = bus.issue_src_a;
    assign bus.selector_b = bus.issue_src_b;
    assign bus.selector_e = bus.res_dst;
    assign bus.data_in    = bus.res_data;

    // Hazards are judged against the registered scoreboard, never the next-state one.
    always_comb begin
        res_hit  = bus.res_valid & pending_q[bus.res_dst];
`ifdef REGFILE_BYPASS_EN
        fwd_a    = res_hit & (bus.issue_src_a == bus.res_dst);
        fwd_b    = res_hit & (bus.issue_src_b == bus.res_dst);
`else
        fwd_a    = 1'b0;
        fwd_b    = 1'b0;
`endif
        pend_cnt = 3'(pending_q[0]) + 3'(pending_q[1]) + 3'(pending_q[2]) + 3'(pending_q[3]);
        raw      = (pending_q[bus.issue_src_a] & ~fwd_a) | (pending_q[bus.issue_src_b] & ~fwd_b);
        waw      = bus.issue_wr & pending_q[bus.issue_dst];
        full     = bus.issue_wr & (pend_cnt == 3'(MAX_PENDING));
        issue_ready = ~areset & (~op_valid_q | bus.op_ready) & ~raw & ~waw & ~full;
        accept   = bus.issue_valid & issue_ready;
        opnd_a   = fwd_a ? bus.res_data : bus.data_out_a;
        opnd_b   = fwd_b ? bus.res_data : bus.data_out_b;
    end

    always_comb begin
        set_mask   = 4'b0000;
        clr_mask   = 4'b0000;
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_dst_d   = op_dst_q;
        op_wr_d    = op_wr_q;
        if (accept && bus.issue_wr) begin
            set_mask = 4'b0001 << bus.issue_dst;
        end
        if (res_hit) begin
            clr_mask = 4'b0001 << bus.res_dst;
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
        err_d     = err_q | (bus.res_valid & ~pending_q[bus.res_dst]);
        if (accept) begin
            op_valid_d = 1'b1;
            op_a_d     = opnd_a;
            op_b_d     = opnd_b;
            op_dst_d   = bus.issue_dst;
            op_wr_d    = bus.issue_wr;
        end else if (op_valid_q && bus.op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (areset) begin
            pending_q  <= 4'b0000;
            op_valid_q <= 1'b0;
            op_a_q     <= 8'h00;
            op_b_q     <= 8'h00;
            op_dst_q   <= 2'd0;
            op_wr_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_dst_q   <= op_dst_d;
            op_wr_q    <= op_wr_d;
            err_q      <= err_d;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.write_bit   = res_hit & ~areset;
    assign bus.op_valid    = op_valid_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_dst      = op_dst_q;
    assign bus.op_wr       = op_wr_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - directed self-checking bench for regfile_access_ctrl
module tb_regfile_access_ctrl;

    logic clk = 1'b0;
    logic areset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] rf [4];

    always #5 clk = ~clk;

    regfile_access_ctrl_if bus ();
    regfile_access_ctrl_if bus2 ();

    regfile_access_ctrl #(.MAX_PENDING(4)) u_dut (
        .CLK    (clk),
        .areset (areset),
        .bus    (bus.master)
    );

    regfile_access_ctrl #(.MAX_PENDING(2)) u_dut2 (
        .CLK    (clk),
        .areset (areset),
        .bus    (bus2.master)
    );

    // Register file model for the main instance
    assign bus.data_out_a = rf[bus.selector_a];
    assign bus.data_out_b = rf[bus.selector_b];
    always @(posedge clk) begin
        if (areset) begin
            rf[0] <= 8'h00;
            rf[1] <= 8'h11;
            rf[2] <= 8'h22;
            rf[3] <= 8'h33;
        end else if (bus.write_bit) begin
            rf[bus.selector_e] <= bus.data_in;
        end
    end

    assign bus2.data_out_a = 8'hA5;
    assign bus2.data_out_b = 8'h5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_issue(input logic v, input logic [1:0] sa, input logic [1:0] sb,
                               input logic [1:0] d, input logic w);
        bus.issue_valid = v;
        bus.issue_src_a = sa;
        bus.issue_src_b = sb;
        bus.issue_dst   = d;
        bus.issue_wr    = w;
    endtask

    task automatic drive_issue2(input logic v, input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] d, input logic w);
        bus2.issue_valid = v;
        bus2.issue_src_a = sa;
        bus2.issue_src_b = sb;
        bus2.issue_dst   = d;
        bus2.issue_wr    = w;
    endtask

    initial begin
        areset = 1'b1;
        drive_issue(0, 0, 0, 0, 0);
        drive_issue2(0, 0, 0, 0, 0);
        bus.op_ready   = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_dst    = 2'd0;
        bus.res_data   = 8'h00;
        bus2.op_ready  = 1'b1;
        bus2.res_valid = 1'b0;
        bus2.res_dst   = 2'd0;
        bus2.res_data  = 8'h00;
        step();
        step();

        // Write enable held off while in reset
        bus.res_valid = 1'b1;
        bus.res_dst   = 2'd1;
        #1;
        check("rst_write_bit", bus.write_bit, 0);
        check("rst_issue_ready", bus.issue_ready, 0);
        step();
        areset = 1'b0;
        bus.res_valid = 1'b0;
        #1;
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_op_a", bus.op_a, 8'h00);
        check("rst_op_b", bus.op_b, 8'h00);
        check("rst_op_dst", bus.op_dst, 0);
        check("rst_op_wr", bus.op_wr, 0);
        check("rst_pending", u_dut.pending_q, 4'b0000);
        check("rst_err", bus.err, 0);
        check("rst_ready_idle", bus.issue_ready, 1);

        // Basic issue and one-cycle operand latency
        drive_issue(1, 2'd1, 2'd2, 2'd3, 1);
        #1;
        check("sel_a", bus.selector_a, 1);
        check("sel_b", bus.selector_b, 2);
        check("issue_ready_basic", bus.issue_ready, 1);
        step();
        bus.issue_valid = 1'b0;
        #1;
        check("op_valid_basic", bus.op_valid, 1);
        check("op_a_basic", bus.op_a, 8'h11);
        check("op_b_basic", bus.op_b, 8'h22);
        check("op_dst_basic", bus.op_dst, 3);
        check("op_wr_basic", bus.op_wr, 1);
        check("pending_basic", u_dut.pending_q, 4'b1000);

        // RAW on R3, released by result writeback
        bus.op_ready = 1'b1;
        drive_issue(1, 2'd3, 2'd0, 2'd0, 0);
        #1;
        check("raw_stall", bus.issue_ready, 0);
        bus.res_valid = 1'b1;
        bus.res_dst   = 2'd3;
        bus.res_data  = 8'h5A;
        #1;
        check("wb_write_bit", bus.write_bit, 1);
        check("wb_selector_e", bus.selector_e, 3);
        check("wb_data_in", bus.data_in, 8'h5A);
`ifdef REGFILE_BYPASS_EN
        check("raw_bypass_ready", bus.issue_ready, 1);
        step();
        bus.res_valid   = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
`else
        check("raw_stall_res_cycle", bus.issue_ready, 0);
        step();
        bus.res_valid = 1'b0;
        #1;
        check("raw_consumed_slot", bus.op_valid, 0);
        check("raw_release", bus.issue_ready, 1);
        step();
        bus.issue_valid = 1'b0;
        #1;
`endif
        check("raw_op_valid", bus.op_valid, 1);
        check("raw_op_a", bus.op_a, 8'h5A);
        check("raw_op_b", bus.op_b, 8'h00);
        check("raw_pending", u_dut.pending_q, 4'b0000);

        // Slot held while the ALU is not ready
        bus.op_ready = 1'b0;
        drive_issue(1, 2'd1, 2'd2, 2'd0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_ready", bus.issue_ready, 0);
            check("hold_op_a", bus.op_a, 8'h5A);
            check("hold_op_b", bus.op_b, 8'h00);
            step();
        end
        bus.op_ready = 1'b1;
        #1;
        check("reload_ready", bus.issue_ready, 1);
        step();
        bus.issue_valid = 1'b0;
        #1;
        check("reload_op_valid", bus.op_valid, 1);
        check("reload_op_a", bus.op_a, 8'h11);
        check("reload_op_b", bus.op_b, 8'h22);
        step();
        #1;
        check("drain_op_valid", bus.op_valid, 0);

        // MAX_PENDING=2 instance: third write-issue stalls, read-only passes
        drive_issue2(1, 2'd0, 2'd0, 2'd0, 1);
        step();
        drive_issue2(1, 2'd2, 2'd2, 2'd1, 1);
        step();
        drive_issue2(1, 2'd3, 2'd3, 2'd2, 1);
        #1;
        check("full_pending", u_dut2.pending_q, 4'b0011);
        check("full_stall", bus2.issue_ready, 0);
        bus2.issue_wr = 1'b0;
        #1;
        check("full_readonly_ready", bus2.issue_ready, 1);
        step();
        bus2.issue_valid = 1'b0;
        #1;
        check("full_readonly_op_valid", bus2.op_valid, 1);
        check("full_readonly_op_wr", bus2.op_wr, 0);
        check("full_readonly_op_a", bus2.op_a, 8'hA5);

        // Spurious result on a non-pending register
        bus.res_valid = 1'b1;
        bus.res_dst   = 2'd2;
        bus.res_data  = 8'h77;
        #1;
        check("spur_write_bit", bus.write_bit, 0);
        step();
        bus.res_valid = 1'b0;
        #1;
        check("spur_err", bus.err, 1);
        step();
        step();
        #1;
        check("spur_err_sticky", bus.err, 1);

        // Concurrent set/clear, WAW against a clearing result
        drive_issue(1, 2'd0, 2'd0, 2'd1, 1);
        #1;
        check("set1_ready", bus.issue_ready, 1);
        step();
        drive_issue(1, 2'd0, 2'd0, 2'd2, 1);
        bus.res_valid = 1'b1;
        bus.res_dst   = 2'd1;
        bus.res_data  = 8'h99;
        #1;
        check("setclr_write_bit", bus.write_bit, 1);
        check("setclr_ready", bus.issue_ready, 1);
        step();
        bus.res_valid = 1'b0;
        drive_issue(1, 2'd0, 2'd0, 2'd1, 1);
        #1;
        check("setclr_pending", u_dut.pending_q, 4'b0100);
        step();
        drive_issue(1, 2'd0, 2'd0, 2'd2, 1);
        bus.res_valid = 1'b1;
        bus.res_dst   = 2'd2;
        bus.res_data  = 8'h42;
        #1;
        check("waw_clear_stall", bus.issue_ready, 0);
        step();
        bus.res_valid = 1'b0;
        #1;
        check("waw_next_ready", bus.issue_ready, 1);
        step();
        bus.issue_valid = 1'b0;
        #1;
        check("pre_rst_pending", u_dut.pending_q, 4'b0110);
        check("pre_rst_op_valid", bus.op_valid, 1);

        // Reset mid-operation
        areset = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_dst   = 2'd1;
        #1;
        check("midrst_write_bit", bus.write_bit, 0);
        check("midrst_ready", bus.issue_ready, 0);
        step();
        areset = 1'b0;
        bus.res_valid = 1'b0;
        #1;
        check("midrst_pending", u_dut.pending_q, 4'b0000);
        check("midrst_op_valid", bus.op_valid, 0);
        check("midrst_err", bus.err, 0);
        bus.res_valid = 1'b1;
        bus.res_dst   = 2'd1;
        #1;
        check("postrst_write_bit", bus.write_bit, 0);
        step();
        bus.res_valid = 1'b0;
        #1;
        check("postrst_err", bus.err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Initiator side of the 4x8-bit two-read/one-write register file. It accepts decoded instructions and drives the register file read selectors. It captures both operands into a registered operand slot for the ALU, then drives the register-file write port when ALU results return. A 4-entry pending-write scoreboard stalls issue on RAW and WAW hazards, so operands are never stale.

Parameters:
MAX_PENDING, 4, maximum simultaneously pending destination registers (1..4); issue stalls when popcount(pending) == MAX_PENDING and the instruction writes.

Ports:
CLK  in  1  clock; all state updates on rising edge
areset  in  1  reset; synchronous, active-high despite the name
issue_valid  in  1  decoded instruction present
issue_ready  out  1  instruction accepted this cycle when high with issue_valid
issue_src_a  in  2  source register A index
issue_src_b  in  2  source register B index
issue_dst  in  2  destination register index
issue_wr  in  1  instruction writes issue_dst
selector_a  out  2  register-file read select A (= issue_src_a, combinational)
selector_b  out  2  register-file read select B (= issue_src_b, combinational)
data_out_a  in  8  register-file read data A (combinational from selector_a)
data_out_b  in  8  register-file read data B
op_valid  out  1  operand slot full
op_ready  in  1  ALU consumes slot
op_a, op_b  out  8 each  captured operands
op_dst  out  2  captured destination
op_wr  out  1  captured write flag
res_valid  in  1  ALU result present; always accepted (no res_ready)
res_dst  in  2  result destination
res_data  in  8  result value
write_bit  out  1  register-file write enable
selector_e  out  2  register-file write select (= res_dst)
data_in  out  8  register-file write data (= res_data)
err  out  1  sticky: result arrived for a non-pending register

Behaviour:
- Reset (areset=1 at edge): op_valid=0, op_a=op_b=0, op_dst=0, op_wr=0, pending=4'b0000, err=0. write_bit is forced 0 while areset=1.
- Reset mid-operation: all pending and in-flight state is discarded. A result arriving after reset for a cleared register sets err; the ALU must be reset together with this block.
- Hazard logic:
  - raw = pending[issue_src_a] | pending[issue_src_b].
  - waw = issue_wr & pending[issue_dst].
  - full = issue_wr & (popcount(pending) == MAX_PENDING).
  - All three use the current registered pending value, not the next-state value.
- Ready: issue_ready = !areset & (!op_valid | op_ready) & !raw & !waw & !full.
- Issue accept (issue_valid & issue_ready) at edge N:
  - op_a <= data_out_a, op_b <= data_out_b, op_dst <= issue_dst, op_wr <= issue_wr, op_valid <= 1.
  - If issue_wr, pending[issue_dst] <= 1.
  - Latency: operands are visible on op_* one cycle after accept.
- Operand slot:
  - If op_valid & op_ready without a new accept: op_valid <= 0.
  - Back-to-back accept plus consume in the same cycle keeps op_valid=1 with the new contents.
  - Slot contents hold stable while op_valid & !op_ready.
- Writeback (combinational): write_bit = res_valid & pending[res_dst] & !areset.
  - Each such result clears pending[res_dst] at the edge.
  - The register file commits at the same edge.
- Spurious result (res_valid & !pending[res_dst]): no write, err <= 1, and err stays 1 until reset.
- Simultaneous result clear of X and issue reading X: still a RAW stall, because register-file read data is stale that cycle. Issue proceeds the next cycle.
- Simultaneous clear of X and issue writing X: WAW stall (current pending used).
- Simultaneous set of X by issue and result for a different Y: both updates apply.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - raw excludes any source equal to res_dst when res_valid & pending[res_dst].
  - That operand is captured from res_data instead of data_out_x.
  - If both sources match, both take res_data.
  - WAW and full rules are unchanged.
- Undefined: no forwarding; behaviour exactly as above.

Test Plan:
- Reset, then issue src_a=1, src_b=2, dst=3, wr=1 with regfile R1=0x11, R2=0x22 -> next cycle op_valid=1, op_a=0x11, op_b=0x22, op_dst=3, pending=4'b1000.
- With R3 pending, issue src_a=3 -> issue_ready=0. Drive res_valid, res_dst=3, res_data=0x5A -> write_bit=1 that cycle. Next cycle issue_ready=1 and op_a=0x5A. With REGFILE_BYPASS_EN, issue is accepted in the res_valid cycle with op_a=0x5A.
- Hold op_ready=0 with slot full -> issue_ready=0 and op_a/op_b unchanged for 5 cycles. Raise op_ready with issue_valid -> slot reloads in the same cycle, op_valid stays 1.
- MAX_PENDING=2: issue writes to R0 then R1 -> a third write-issue to R2 stalls; a read-only issue (wr=0, sources R3) is accepted.
- res_valid with res_dst=2, pending[2]=0 -> write_bit=0, err=1 next cycle, and err stays 1 until areset.
- Assert areset with pending=4'b0110 and op_valid=1 -> next cycle pending=0, op_valid=0, err=0. write_bit=0 during reset even with res_valid=1.
